// File: rtl/sc_backg_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sc_backg_lane_scheduler
// Brief    : Level-timed round-robin shift sequencer for the Frogger lane
//            register bank; tracks level, game-over and victory.
//            Optional macro SC_BACKGSCHED_PAUSE_EN adds a RUN-stall input.
// Revision : 1.0
// ============================================================================
module sc_backg_lane_scheduler #(
    parameter int                         LANES          = 4,
    parameter int                         PRESCALE_WIDTH = 24,
    parameter logic [PRESCALE_WIDTH-1:0]  BASE_PERIOD    = 24'd2500000,
    parameter logic [LANES-1:0]           LANE_MASK      = {LANES{1'b1}}
) (
    input  logic                   SC_BACKGSCHED_CLOCK_50,
    input  logic                   SC_BACKGSCHED_RESET_InLow,
    input  logic                   SC_BACKGSCHED_start_InLow,
    input  logic                   SC_BACKGSCHED_levelup_InLow,
    input  logic                   SC_BACKGSCHED_gameover_InLow,
`ifdef SC_BACKGSCHED_PAUSE_EN
    input  logic                   SC_BACKGSCHED_pause_InLow,
`endif
    output logic                   SC_BACKGSCHED_clear_OutLow,
    output logic [2*LANES-1:0]     SC_BACKGSCHED_shiftselection_OutBUS,
    output logic [2:0]             SC_BACKGSCHED_transitioncounter_OutBUS,
    output logic [1:0]             SC_BACKGSCHED_state_OutBUS,
    output logic                   SC_BACKGSCHED_victory_Out
);

    localparam int          c_PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0]  c_IDLE = 2'b00;
    localparam logic [1:0]  c_LOAD = 2'b01;
    localparam logic [1:0]  c_RUN  = 2'b10;
    localparam logic [1:0]  c_OVER = 2'b11;

    logic [1:0]                r_state;
    logic [1:0]                r_level;
    logic                      r_clearN;
    logic                      r_victory;
    logic [2*LANES-1:0]        r_shiftSel;
    logic [PRESCALE_WIDTH-1:0] r_prescaler;
    logic [c_PTR_W-1:0]        r_pointer;

    logic [PRESCALE_WIDTH-1:0] w_period;
    logic                      w_tick;
    logic                      w_paused;
    logic [c_PTR_W-1:0]        w_pointerNext;
    logic [2*LANES-1:0]        w_pulse;

`ifdef SC_BACKGSCHED_PAUSE_EN
    assign w_paused = ~SC_BACKGSCHED_pause_InLow;
`else
    assign w_paused = 1'b0;
`endif

    // Level is updated on entry to LOAD, so the period here is never stale in RUN.
    assign w_period      = BASE_PERIOD >> r_level;
    assign w_tick        = (r_prescaler == (w_period - PRESCALE_WIDTH'(1)));
    assign w_pointerNext = (r_pointer == c_PTR_W'(LANES - 1)) ? '0 : r_pointer + 1'b1;

    always_comb begin
        w_pulse = '0;
        if (LANE_MASK[r_pointer]) begin
            w_pulse[2*r_pointer +: 2] = r_pointer[0] ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge SC_BACKGSCHED_CLOCK_50 or negedge SC_BACKGSCHED_RESET_InLow) begin
        if (!SC_BACKGSCHED_RESET_InLow) begin
            r_state     <= c_IDLE;
            r_level     <= 2'd0;
            r_clearN    <= 1'b0;
            r_victory   <= 1'b0;
            r_shiftSel  <= '0;
            r_prescaler <= '0;
            r_pointer   <= '0;
        end else begin
            r_shiftSel <= '0;
            r_victory  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_clearN <= 1'b0;
                    if (!SC_BACKGSCHED_start_InLow) begin
                        r_state  <= c_LOAD;
                        r_level  <= 2'd0;
                        r_clearN <= 1'b1;
                    end
                end
                c_LOAD: begin
                    r_clearN    <= 1'b1;
                    r_prescaler <= '0;
                    r_pointer   <= '0;
                    r_state     <= c_RUN;
                end
                c_RUN: begin
                    if (!SC_BACKGSCHED_gameover_InLow) begin
                        r_state <= c_OVER;
                    end else if (!SC_BACKGSCHED_levelup_InLow) begin
                        if (r_level == 2'd3) begin
                            r_victory <= 1'b1;
                            r_level   <= 2'd0;
                            r_clearN  <= 1'b0;
                            r_state   <= c_IDLE;
                        end else begin
                            r_level <= r_level + 2'd1;
                            r_state <= c_LOAD;
                        end
                    end else if (!w_paused) begin
                        if (w_tick) begin
                            r_prescaler <= '0;
                            r_pointer   <= w_pointerNext;
                            r_shiftSel  <= w_pulse;
                        end else begin
                            r_prescaler <= r_prescaler + 1'b1;
                        end
                    end
                end
                c_OVER: begin
                    if (!SC_BACKGSCHED_start_InLow) begin
                        r_state <= c_LOAD;
                        r_level <= 2'd0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign SC_BACKGSCHED_clear_OutLow             = r_clearN;
    assign SC_BACKGSCHED_shiftselection_OutBUS    = r_shiftSel;
    assign SC_BACKGSCHED_transitioncounter_OutBUS = {1'b0, r_level};
    assign SC_BACKGSCHED_state_OutBUS             = r_state;
    assign SC_BACKGSCHED_victory_Out              = r_victory;

endmodule
`default_nettype wire

// File: tb/tb_sc_backg_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_backg_lane_scheduler
// Brief    : Self-checking bench: directed scenarios plus random events
//            against a run-count based model (optional SC_BACKGSCHED_PAUSE_EN).
// Revision : 1.0
// ============================================================================
module tb_sc_backg_lane_scheduler;

    localparam int         LANES = 4;
    localparam int         BASE  = 16;
    localparam logic [3:0] MASK_A = 4'b1111;
    localparam logic [3:0] MASK_B = 4'b1011;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic startN = 1'b1, levelupN = 1'b1, gameoverN = 1'b1, pauseN = 1'b1;

    logic       clrA, clrB, vicA, vicB;
    logic [7:0] shA, shB;
    logic [2:0] lvlA, lvlB;
    logic [1:0] stA, stB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_backg_lane_scheduler #(.LANES(LANES), .PRESCALE_WIDTH(24), .BASE_PERIOD(24'd16), .LANE_MASK(MASK_A)) dut (
        .SC_BACKGSCHED_CLOCK_50(clk), .SC_BACKGSCHED_RESET_InLow(rstN),
        .SC_BACKGSCHED_start_InLow(startN), .SC_BACKGSCHED_levelup_InLow(levelupN),
        .SC_BACKGSCHED_gameover_InLow(gameoverN),
`ifdef SC_BACKGSCHED_PAUSE_EN
        .SC_BACKGSCHED_pause_InLow(pauseN),
`endif
        .SC_BACKGSCHED_clear_OutLow(clrA), .SC_BACKGSCHED_shiftselection_OutBUS(shA),
        .SC_BACKGSCHED_transitioncounter_OutBUS(lvlA), .SC_BACKGSCHED_state_OutBUS(stA),
        .SC_BACKGSCHED_victory_Out(vicA));

    sc_backg_lane_scheduler #(.LANES(LANES), .PRESCALE_WIDTH(24), .BASE_PERIOD(24'd16), .LANE_MASK(MASK_B)) dutM (
        .SC_BACKGSCHED_CLOCK_50(clk), .SC_BACKGSCHED_RESET_InLow(rstN),
        .SC_BACKGSCHED_start_InLow(startN), .SC_BACKGSCHED_levelup_InLow(levelupN),
        .SC_BACKGSCHED_gameover_InLow(gameoverN),
`ifdef SC_BACKGSCHED_PAUSE_EN
        .SC_BACKGSCHED_pause_InLow(pauseN),
`endif
        .SC_BACKGSCHED_clear_OutLow(clrB), .SC_BACKGSCHED_shiftselection_OutBUS(shB),
        .SC_BACKGSCHED_transitioncounter_OutBUS(lvlB), .SC_BACKGSCHED_state_OutBUS(stB),
        .SC_BACKGSCHED_victory_Out(vicB));

    // Model: game mode, level, and k = 1-based count of advancing RUN cycles since LOAD.
    logic [1:0] mState;
    int         mLevel, mK;
    bit         mAdv, mVic;
    logic       mPaused;

`ifdef SC_BACKGSCHED_PAUSE_EN
    assign mPaused = ~pauseN;
`else
    assign mPaused = 1'b0;
`endif

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mState = 2'd0; mLevel = 0; mK = 0; mAdv = 0; mVic = 0;
        end else begin
            mVic = 0;
            mAdv = 0;
            case (mState)
                2'd0: if (!startN) begin mState = 2'd1; mLevel = 0; end
                2'd1: begin mState = 2'd2; mK = 1; end
                2'd2: begin
                    if (!gameoverN) mState = 2'd3;
                    else if (!levelupN) begin
                        if (mLevel == 3) begin mVic = 1; mLevel = 0; mState = 2'd0; end
                        else begin mLevel = mLevel + 1; mState = 2'd1; end
                    end else if (!mPaused) begin
                        mK = mK + 1; mAdv = 1;
                    end
                end
                default: if (!startN) begin mState = 2'd1; mLevel = 0; end
            endcase
        end
    end

    function automatic logic [7:0] expShift(input logic [3:0] mask);
        logic [7:0] v;
        int p, lane;
        v = 8'h00;
        p = BASE >> mLevel;
        if (mState == 2'd2 && mAdv && mK > 1 && ((mK - 1) % p) == 0) begin
            lane = (((mK - 1) / p) - 1) % LANES;
            if (mask[lane]) v[2*lane +: 2] = (lane % 2 == 1) ? 2'b10 : 2'b01;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstN) begin
            check("model_state", {30'd0, stA}, {30'd0, mState});
            check("model_clear", {31'd0, clrA}, {31'd0, mState != 2'd0});
            check("model_level", {29'd0, lvlA}, mLevel);
            check("model_victory", {31'd0, vicA}, {31'd0, mVic});
            check("model_shift", {24'd0, shA}, {24'd0, expShift(MASK_A)});
            check("model_shift_masked", {24'd0, shB}, {24'd0, expShift(MASK_B)});
            check("model_state_masked", {30'd0, stB}, {30'd0, mState});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseStart();
        startN = 1'b0; cyc(1); startN = 1'b1;
    endtask

    initial begin
        cyc(3);
        check("reset_state", {30'd0, stA}, 0);
        check("reset_clear", {31'd0, clrA}, 0);
        check("reset_shift", {24'd0, shA}, 0);
        check("reset_level", {29'd0, lvlA}, 0);
        check("reset_victory", {31'd0, vicA}, 0);
        rstN = 1'b1;
        cyc(2);

        // Start: one LOAD cycle, then RUN; lane0 pulse on RUN cycle 17.
        pulseStart();
        check("load_state", {30'd0, stA}, 1);
        check("load_clear", {31'd0, clrA}, 1);
        cyc(1);
        check("run_state", {30'd0, stA}, 2);
        cyc(15);
        check("no_pulse_c16", {24'd0, shA}, 0);
        cyc(1);
        check("lane0_pulse", {24'd0, shA}, 8'h01);
        check("lane0_pulse_m", {24'd0, shB}, 8'h01);
        cyc(1);
        check("pulse_one_cycle", {24'd0, shA}, 0);
        cyc(15);
        check("lane1_pulse", {24'd0, shA}, 8'h08);
        cyc(16);
        check("lane2_pulse", {24'd0, shA}, 8'h10);
        check("lane2_masked", {24'd0, shB}, 8'h00);
        cyc(16);
        check("lane3_pulse", {24'd0, shA}, 8'h80);
        check("lane3_pulse_m", {24'd0, shB}, 8'h80);
        cyc(16);
        check("lane0_wrap", {24'd0, shA}, 8'h01);

        // Level up twice: level 2 gives 4-cycle spacing.
        cyc(3);
        levelupN = 1'b0; cyc(1); levelupN = 1'b1;
        check("lvl1_load", {30'd0, stA}, 1);
        check("lvl1_value", {29'd0, lvlA}, 1);
        cyc(1);
        levelupN = 1'b0; cyc(1); levelupN = 1'b1;
        check("lvl2_value", {29'd0, lvlA}, 2);
        cyc(1);
        cyc(4);
        check("lvl2_lane0", {24'd0, shA}, 8'h01);
        cyc(4);
        check("lvl2_lane1", {24'd0, shA}, 8'h08);

        // Level 3 completion gives victory and returns to IDLE.
        levelupN = 1'b0; cyc(1); levelupN = 1'b1;
        check("lvl3_value", {29'd0, lvlA}, 3);
        cyc(3);
        levelupN = 1'b0; cyc(1); levelupN = 1'b1;
        check("victory_pulse", {31'd0, vicA}, 1);
        check("victory_state", {30'd0, stA}, 0);
        check("victory_level", {29'd0, lvlA}, 0);
        check("victory_clear", {31'd0, clrA}, 0);
        cyc(1);
        check("victory_once", {31'd0, vicA}, 0);

        // Gameover beats a simultaneous levelup; board frozen in OVER.
        pulseStart();
        cyc(6);
        levelupN = 1'b0; cyc(1); levelupN = 1'b1;
        cyc(4);
        gameoverN = 1'b0; levelupN = 1'b0; cyc(1); gameoverN = 1'b1; levelupN = 1'b1;
        check("over_state", {30'd0, stA}, 3);
        check("over_level", {29'd0, lvlA}, 1);
        check("over_clear", {31'd0, clrA}, 1);
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            check("over_frozen", {24'd0, shA}, 0);
        end
        pulseStart();
        check("restart_load", {30'd0, stA}, 1);
        check("restart_level", {29'd0, lvlA}, 0);

        // Async reset during a pulse.
        cyc(17);
        check("pre_reset_pulse", {24'd0, shA}, 8'h01);
        #1 rstN = 1'b0;
        #1;
        check("async_state", {30'd0, stA}, 0);
        check("async_shift", {24'd0, shA}, 0);
        check("async_clear", {31'd0, clrA}, 0);
        cyc(2);
        rstN = 1'b1;
        cyc(3);
        check("post_reset_idle", {30'd0, stA}, 0);

`ifdef SC_BACKGSCHED_PAUSE_EN
        pulseStart();
        cyc(10);
        pauseN = 1'b0; cyc(10); pauseN = 1'b1;
        cyc(6);
        check("pause_no_early", {24'd0, shA}, 0);
        cyc(1);
        check("pause_delayed_pulse", {24'd0, shA}, 8'h01);
`endif

        for (int i = 0; i < 4000; i++) begin
            cyc(1);
            startN    = ($urandom % 25) != 0;
            levelupN  = ($urandom % 60) != 0;
            gameoverN = ($urandom % 200) != 0;
`ifdef SC_BACKGSCHED_PAUSE_EN
            if (($urandom % 40) == 0) pauseN = ~pauseN;
`endif
        end
        startN = 1'b1; levelupN = 1'b1; gameoverN = 1'b1; pauseN = 1'b1;
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sc_backg_lane_scheduler.md
Name: sc_backg_lane_scheduler

Overview:
Sequences a bank of LANES background-type registers, one per road/river lane, in the Frogger datapath. Drives each lane register's clear, shift-selection and level (transition-counter) inputs. Generates level-dependent shift timing with round-robin lane service, and tracks level progression, game-over and victory. Sits between the game-control FSM (start/levelup/gameover events) and the background register bank.

Parameters:
LANES, 4, number of lane registers served (2..8)
PRESCALE_WIDTH, 24, prescaler counter width
BASE_PERIOD, 24'd2500000, level-0 cycles between shift ticks; level L period = BASE_PERIOD >> L (must stay >=1)
LANE_MASK, {LANES{1'b1}}, bit i = 1: lane i receives shifts; 0: its tick is consumed silently

Ports:
SC_BACKGSCHED_CLOCK_50  in  1  system clock
SC_BACKGSCHED_RESET_InLow  in  1  asynchronous active-low reset
SC_BACKGSCHED_start_InLow  in  1  start/restart request, active low, level-sampled
SC_BACKGSCHED_levelup_InLow  in  1  frog reached goal, active low, one-cycle pulse
SC_BACKGSCHED_gameover_InLow  in  1  frog died, active low, one-cycle pulse
SC_BACKGSCHED_clear_OutLow  out  1  clear to all lane registers, active low
SC_BACKGSCHED_shiftselection_OutBUS  out  2*LANES  lane i in bits [2i+1:2i]; 01 rotate left, 10 rotate right, 00 hold
SC_BACKGSCHED_transitioncounter_OutBUS  out  3  current level 0..3 (bit 2 always 0)
SC_BACKGSCHED_state_OutBUS  out  2  FSM state: IDLE=00, LOAD=01, RUN=10, OVER=11
SC_BACKGSCHED_victory_Out  out  1  one-cycle pulse when level 3 is completed

Behaviour:
- All outputs registered. Reset (async, RESET_InLow=0) forces: state IDLE, clear_OutLow=0, shiftselection=0, level=0, victory=0, prescaler=0, lane pointer=0. Release takes effect on the next clock edge.
- IDLE: clear_OutLow=0. start=0 -> LOAD with level=0.
- LOAD (exactly 1 cycle): clear_OutLow=1, prescaler=0, pointer=0, no shifts -> RUN.
- RUN: clear_OutLow=1. Prescaler counts 0..P-1, where P = BASE_PERIOD >> level. At count P-1 the prescaler wraps to 0, the pointer advances (LANES-1 wraps to 0), and in the next cycle lane[pointer] gets a one-cycle shift pulse (even lane 01, odd lane 10) if LANE_MASK[pointer]=1.
- At most one lane is pulsed per cycle, and no pulse lasts longer than 1 cycle.
- RUN events, priority gameover > levelup > tick:
  - gameover=0 -> OVER. Level holds; a pending tick is dropped.
  - levelup=0, level<3 -> level+1, LOAD.
  - levelup=0, level=3 -> victory=1 for 1 cycle, level=0, IDLE.
- OVER: shifts 0, clear_OutLow=1 (board frozen), level held. start=0 -> LOAD with level=0.
- Inputs not listed for a state are ignored in that state. start held low in RUN has no effect.
- Period change applies from the LOAD cycle; P is never computed with a stale level.
- Reset asserted mid-RUN or mid-LOAD aborts immediately, with no residual pulse after release.

Optional Feature:
SC_BACKGSCHED_PAUSE_EN
- Defined: adds input SC_BACKGSCHED_pause_InLow. While it is 0 in RUN, the prescaler and pointer freeze and no shifts are issued. Events keep their normal priority. Releasing it resumes counting from the frozen value, so no tick is lost or duplicated.
- Undefined: the port is absent and RUN is never stalled.

Test Plan:
1. BASE_PERIOD=16, LANES=4: reset, start=0 for 1 cycle -> state 01 for 1 cycle, then 10; first lane0=01 pulse on the 17th RUN cycle; lanes 1,2,3,0 follow every 16 cycles (lane1=10, lane2=01, lane3=10).
2. Two levelup pulses from level 0 -> transitioncounter 1 then 2, one LOAD cycle each; at level 2 the pulse spacing is 4 cycles.
3. levelup at level 3 -> victory=1 for exactly 1 cycle, transitioncounter=0, state 00, clear_OutLow=0.
4. gameover and levelup low in the same RUN cycle -> state 11, level unchanged, shiftselection stays 0 for 100 cycles; then start=0 -> LOAD, level 0.
5. LANE_MASK=4'b1011 -> lane2 never pulses and its slot stays silent; lanes 0,1,3 keep 16-cycle spacing relative to the pointer.
6. RESET_InLow=0 mid-pulse -> all outputs at reset values within the same cycle (async); with PAUSE_EN, pause for 10 cycles delays the next pulse by exactly 10 cycles.
